// File: rtl/tdc_gpx_sequencer.sv
// tdc_gpx_sequencer
//   Drives a TDC-GPX register controller through one start-up sequence and then
//   continuous FIFO readout:
//   1. NUM_CFG table writes, with the table supplied externally through cfg_idx,
//      cfg_addr and cfg_data.
//   2. A master-reset write.
//   3. Readout of FIFO1 (addr 8) and FIFO2 (addr 9), one word at a time, handed
//      downstream with a valid/ready hold.
//
//   Ports:
//     clk, reset       - single clock, synchronous active-high reset
//     start, stop      - begin configuration / leave readout (ARMED only)
//     cfg_idx          - table index requested; cfg_addr/cfg_data answer it
//     tdc_ef1/tdc_ef2  - FIFO empty flags (1 = empty)
//     ctl_*            - controller handshake:
//                        - one-cycle ctl_mem_op strobe, ctl_read_write = 1 for a read;
//                        - ctl_ready is the controller-idle flag;
//                        - ctl_data_ready strobes read data.
//     hit_*            - captured FIFO word, source channel and valid/ready handshake
//     busy, cfg_done   - not IDLE / readout armed
//     error            - sticky watchdog error
//
//   Optional feature: define TDC_SEQ_TIMEOUT_EN to add a watchdog on every WAIT
//   state. Without it error is tied low and WAIT states wait forever.

module tdc_gpx_sequencer #(
  parameter int unsigned  NUM_CFG   = 11,
  parameter logic [3:0]   MRST_ADDR = 4'd4,
  parameter logic [27:0]  MRST_DATA = 28'h0400000,
  parameter int unsigned  TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  cfg_idx,
  input  logic [3:0]  cfg_addr,
  input  logic [27:0] cfg_data,
  input  logic        tdc_ef1,
  input  logic        tdc_ef2,
  input  logic        ctl_ready,
  output logic        ctl_mem_op,
  output logic        ctl_read_write,
  output logic [3:0]  ctl_addr,
  output logic [27:0] ctl_data_in,
  input  logic [27:0] ctl_data_out,
  input  logic        ctl_data_ready,
  output logic [27:0] hit_data,
  output logic        hit_chan,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic        busy,
  output logic        cfg_done,
  output logic        error
);

  if (NUM_CFG < 1 || NUM_CFG > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("tdc_gpx_sequencer: NUM_CFG or TIMEOUT out of range");
  end

  typedef enum logic [3:0] {
    IDLE, CFG_ISSUE, CFG_WAIT, MRST_ISSUE, MRST_WAIT,
    ARMED, RD_ISSUE, RD_WAIT, HOLD
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NUM_CFG - 1);
  localparam logic [3:0] FIFO1_ADDR = 4'd8;
  localparam logic [3:0] FIFO2_ADDR = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  cfg_idx_q, cfg_idx_d;
  logic        mem_op_q, mem_op_d;
  logic        rw_q, rw_d;
  logic [3:0]  addr_q, addr_d;
  logic [27:0] wdata_q, wdata_d;
  logic [27:0] hit_data_q, hit_data_d;
  logic        hit_chan_q, hit_chan_d;
  logic        hit_valid_q, hit_valid_d;
  logic        busy_q, busy_d;
  logic        cfg_done_q, cfg_done_d;
  // rr_next is the FIFO to prefer when both have data (0 = FIFO1).
  logic        rr_next_q, rr_next_d;
  logic        sel;
  // A write completes on ctl_ready, but ctl_ready is still the pre-issue value
  // in the cycle the strobe is visible, so that cycle is skipped.
  logic        write_done;

`ifdef TDC_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0]  wdog_q, wdog_d;
  logic        error_q, error_d;
  logic        in_wait;
`endif

  always_comb begin
    state_d     = state_q;
    cfg_idx_d   = cfg_idx_q;
    mem_op_d    = 1'b0;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hit_data_d  = hit_data_q;
    hit_chan_d  = hit_chan_q;
    hit_valid_d = hit_valid_q;
    cfg_done_d  = cfg_done_q;
    rr_next_d   = rr_next_q;
    sel         = 1'b0;
    write_done  = !mem_op_q && ctl_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_idx_d = 4'd0;
          state_d   = CFG_ISSUE;
        end
      end
      CFG_ISSUE: begin
        if (ctl_ready) begin
          mem_op_d = 1'b1;
          rw_d     = 1'b0;
          addr_d   = cfg_addr;
          wdata_d  = cfg_data;
          state_d  = CFG_WAIT;
        end
      end
      CFG_WAIT: begin
        if (write_done) begin
          if (cfg_idx_q == LAST_IDX) begin
            state_d = MRST_ISSUE;
          end else begin
            cfg_idx_d = cfg_idx_q + 4'd1;
            state_d   = CFG_ISSUE;
          end
        end
      end
      MRST_ISSUE: begin
        if (ctl_ready) begin
          mem_op_d = 1'b1;
          rw_d     = 1'b0;
          addr_d   = MRST_ADDR;
          wdata_d  = MRST_DATA;
          state_d  = MRST_WAIT;
        end
      end
      MRST_WAIT: begin
        if (write_done) begin
          cfg_done_d = 1'b1;
          state_d    = ARMED;
        end
      end
      ARMED: begin
        if (stop) begin
          cfg_done_d = 1'b0;
          state_d    = IDLE;
        end else if (!(tdc_ef1 && tdc_ef2)) begin
          // With only one FIFO non-empty, ef1=1 means FIFO2 is the one with data.
          sel        = (!tdc_ef1 && !tdc_ef2) ? rr_next_q : tdc_ef1;
          hit_chan_d = sel;
          rr_next_d  = ~sel;
          state_d    = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (ctl_ready) begin
          mem_op_d = 1'b1;
          rw_d     = 1'b1;
          addr_d   = hit_chan_q ? FIFO2_ADDR : FIFO1_ADDR;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ctl_data_ready) begin
          hit_data_d  = ctl_data_out;
          hit_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (hit_ready) begin
          hit_valid_d = 1'b0;
          state_d     = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TDC_SEQ_TIMEOUT_EN
    // The watchdog counts only while a WAIT state is still waiting.
    // Any state change restarts it.
    error_d = error_q;
    wdog_d  = 8'd0;
    in_wait = (state_q == CFG_WAIT) || (state_q == MRST_WAIT) || (state_q == RD_WAIT);
    if (in_wait && (state_d == state_q)) begin
      wdog_d = wdog_q + 8'd1;
      if (wdog_d == TIMEOUT_CNT) begin
        error_d    = 1'b1;
        cfg_done_d = 1'b0;
        wdog_d     = 8'd0;
        state_d    = IDLE;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cfg_idx_q   <= 4'd0;
      mem_op_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 4'd0;
      wdata_q     <= 28'd0;
      hit_data_q  <= 28'd0;
      hit_chan_q  <= 1'b0;
      hit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      rr_next_q   <= 1'b0;
`ifdef TDC_SEQ_TIMEOUT_EN
      wdog_q      <= 8'd0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_idx_q   <= cfg_idx_d;
      mem_op_q    <= mem_op_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hit_data_q  <= hit_data_d;
      hit_chan_q  <= hit_chan_d;
      hit_valid_q <= hit_valid_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
      rr_next_q   <= rr_next_d;
`ifdef TDC_SEQ_TIMEOUT_EN
      wdog_q      <= wdog_d;
      error_q     <= error_d;
`endif
    end
  end

  assign cfg_idx        = cfg_idx_q;
  assign ctl_mem_op     = mem_op_q;
  assign ctl_read_write = rw_q;
  assign ctl_addr       = addr_q;
  assign ctl_data_in    = wdata_q;
  assign hit_data       = hit_data_q;
  assign hit_chan       = hit_chan_q;
  assign hit_valid      = hit_valid_q;
  assign busy           = busy_q;
  assign cfg_done       = cfg_done_q;
`ifdef TDC_SEQ_TIMEOUT_EN
  assign error          = error_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_gpx_sequencer.sv
// tb_tdc_gpx_sequencer
//   Directed bench for tdc_gpx_sequencer with default parameters.
//   - A small controller model holds ctl_ready low for 4 cycles after each
//     operation. For reads, it then strobes ctl_data_ready with rd_data + addr[0].
//   - Expected controller operations and hit words are queued as each step is
//     driven, then popped and compared when the DUT produces them.

module tb_tdc_gpx_sequencer;

  typedef struct packed {
    logic        rw;
    logic [3:0]  addr;
    logic [27:0] data;
  } op_t;

  typedef struct packed {
    logic [27:0] data;
    logic        chan;
  } hit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  cfg_idx;
  logic [3:0]  cfg_addr;
  logic [27:0] cfg_data;
  logic        tdc_ef1 = 1'b1;
  logic        tdc_ef2 = 1'b1;
  logic        ctl_ready = 1'b1;
  logic        ctl_mem_op;
  logic        ctl_read_write;
  logic [3:0]  ctl_addr;
  logic [27:0] ctl_data_in;
  logic [27:0] ctl_data_out = 28'd0;
  logic        ctl_data_ready = 1'b0;
  logic [27:0] hit_data;
  logic        hit_chan;
  logic        hit_valid;
  logic        hit_ready = 1'b0;
  logic        busy;
  logic        cfg_done;
  logic        error;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   op_seen = 0;
  int   hit_seen = 0;
  int   last_op_cyc = 0;
  op_t  exp_ops[$];
  hit_t exp_hits[$];
  op_t  mon_op;
  hit_t mon_hit;
  logic hit_valid_prev = 1'b0;

  logic [27:0] rd_data = 28'd0;
  logic        stuck = 1'b0;
  int          ready_cnt = 0;
  logic        rd_pending = 1'b0;
  logic [3:0]  rd_addr = 4'd0;

  tdc_gpx_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .tdc_ef1(tdc_ef1), .tdc_ef2(tdc_ef2),
    .ctl_ready(ctl_ready), .ctl_mem_op(ctl_mem_op), .ctl_read_write(ctl_read_write),
    .ctl_addr(ctl_addr), .ctl_data_in(ctl_data_in), .ctl_data_out(ctl_data_out),
    .ctl_data_ready(ctl_data_ready),
    .hit_data(hit_data), .hit_chan(hit_chan), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .busy(busy), .cfg_done(cfg_done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Configuration table answering cfg_idx; every entry is distinct.
  function automatic logic [3:0] tbl_addr(input logic [3:0] idx);
    return idx ^ 4'hC;
  endfunction

  function automatic logic [27:0] tbl_data(input logic [3:0] idx);
    return 28'h0A50000 + 28'(idx) * 28'h0000101;
  endfunction

  assign cfg_addr = tbl_addr(cfg_idx);
  assign cfg_data = tbl_data(cfg_idx);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle pulse on start and/or stop, driven between clock edges.
  task automatic applyStimulus(input logic start_v, input logic stop_v);
    start = start_v;
    stop  = stop_v;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Controller model: busy for 4 cycles after each strobe; reads return data.
  always @(negedge clk) begin
    ctl_data_ready = 1'b0;
    if (reset) begin
      ready_cnt  = 0;
      ctl_ready  = 1'b1;
      rd_pending = 1'b0;
    end else if (ctl_mem_op) begin
      ready_cnt  = 4;
      ctl_ready  = 1'b0;
      rd_pending = ctl_read_write;
      rd_addr    = ctl_addr;
    end else if (ready_cnt != 0) begin
      ready_cnt--;
      if (ready_cnt == 0) begin
        ctl_ready = 1'b1;
        if (rd_pending) begin
          ctl_data_ready = 1'b1;
          ctl_data_out   = rd_data + {27'd0, rd_addr[0]};
          rd_pending     = 1'b0;
        end
      end
    end
    if (stuck) ctl_ready = 1'b0;
  end

  // Scoreboard side: every strobe and every new hit must match the queue head.
  always @(negedge clk) begin
    if (ctl_mem_op === 1'b1) begin
      op_seen++;
      last_op_cyc = cyc;
      if (exp_ops.size() == 0) begin
        checkOutput("unexpected_mem_op", {28'd0, ctl_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_op = exp_ops.pop_front();
        checkOutput("op_rw", {31'd0, ctl_read_write}, {31'd0, mon_op.rw});
        checkOutput("op_addr", {28'd0, ctl_addr}, {28'd0, mon_op.addr});
        if (!mon_op.rw) checkOutput("op_wdata", {4'd0, ctl_data_in}, {4'd0, mon_op.data});
      end
    end
    if (hit_valid === 1'b1 && !hit_valid_prev) begin
      hit_seen++;
      if (exp_hits.size() == 0) begin
        checkOutput("unexpected_hit", {4'd0, hit_data}, 32'hFFFF_FFFF);
      end else begin
        mon_hit = exp_hits.pop_front();
        checkOutput("hit_data", {4'd0, hit_data}, {4'd0, mon_hit.data});
        checkOutput("hit_chan", {31'd0, hit_chan}, {31'd0, mon_hit.chan});
      end
    end
    hit_valid_prev = (hit_valid === 1'b1);
  end

  initial begin
    int n;
    int base;

    $display("[TB] start");
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("rst_mem_op", {31'd0, ctl_mem_op}, 32'd0);
    checkOutput("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_cfg_idx", {28'd0, cfg_idx}, 32'd0);
    checkOutput("rst_hit_data", {4'd0, hit_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full configuration: 11 table writes, then the master reset.
    for (int i = 0; i < 11; i++)
      exp_ops.push_back('{rw: 1'b0, addr: tbl_addr(4'(i)), data: tbl_data(4'(i))});
    exp_ops.push_back('{rw: 1'b0, addr: 4'd4, data: 28'h0400000});
    applyStimulus(1'b1, 1'b0);
    checkOutput("cfg_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (cfg_done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    checkOutput("cfg_done", {31'd0, cfg_done}, 32'd1);
    checkOutput("cfg_op_count", op_seen, 32'd12);
    checkOutput("cfg_ops_left", exp_ops.size(), 32'd0);

    // Single FIFO1 read.
    rd_data = 28'h1234567;
    exp_ops.push_back('{rw: 1'b1, addr: 4'd8, data: 28'd0});
    exp_hits.push_back('{data: 28'h1234567, chan: 1'b0});
    tdc_ef1 = 1'b0;
    n = 0;
    while (hit_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tdc_ef1 = 1'b1;
    checkOutput("rd1_valid", {31'd0, hit_valid}, 32'd1);

    // Downstream stalls for 10 cycles: the word must hold, no new strobe.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_data", {4'd0, hit_data}, 32'h1234567);
      checkOutput("hold_valid", {31'd0, hit_valid}, 32'd1);
      checkOutput("hold_no_op", {31'd0, ctl_mem_op}, 32'd0);
    end

    // Release: exactly one more FIFO1 read follows.
    rd_data = 28'h7654321;
    exp_ops.push_back('{rw: 1'b1, addr: 4'd8, data: 28'd0});
    exp_hits.push_back('{data: 28'h7654321, chan: 1'b0});
    tdc_ef1   = 1'b0;
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;
    checkOutput("release_valid_low", {31'd0, hit_valid}, 32'd0);
    n = 0;
    while (hit_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tdc_ef1 = 1'b1;
    checkOutput("rd2_valid", {31'd0, hit_valid}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;

    // Both FIFOs non-empty: FIFO1 was served last, so FIFO2 comes first.
    rd_data = 28'h0F0F0F0;
    for (int i = 0; i < 2; i++) begin
      exp_ops.push_back('{rw: 1'b1, addr: 4'd9, data: 28'd0});
      exp_hits.push_back('{data: 28'h0F0F0F1, chan: 1'b1});
      exp_ops.push_back('{rw: 1'b1, addr: 4'd8, data: 28'd0});
      exp_hits.push_back('{data: 28'h0F0F0F0, chan: 1'b0});
    end
    base      = hit_seen;
    tdc_ef1   = 1'b0;
    tdc_ef2   = 1'b0;
    hit_ready = 1'b1;
    n = 0;
    while (hit_seen < base + 4 && n < 200) begin @(negedge clk); n++; end
    tdc_ef1 = 1'b1;
    tdc_ef2 = 1'b1;
    checkOutput("rr_hits", hit_seen - base, 32'd4);
    repeat (4) @(negedge clk);
    hit_ready = 1'b0;
    checkOutput("rr_ops_left", exp_ops.size(), 32'd0);

    // stop in ARMED returns to IDLE.
    checkOutput("armed_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_busy", {31'd0, busy}, 32'd0);
    checkOutput("stop_cfg_done", {31'd0, cfg_done}, 32'd0);

    // Reset while CFG_WAIT: IDLE next cycle and no further strobes.
    exp_ops.push_back('{rw: 1'b0, addr: tbl_addr(4'd0), data: tbl_data(4'd0)});
    base = op_seen;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (op_seen == base && n < 20) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_cfg_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("midrst_cfg_idx", {28'd0, cfg_idx}, 32'd0);
    base = op_seen;
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_op", op_seen - base, 32'd0);

    // Controller stuck busy after the first write.
    exp_ops.push_back('{rw: 1'b0, addr: tbl_addr(4'd0), data: tbl_data(4'd0)});
    base = op_seen;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (op_seen == base && n < 20) begin @(negedge clk); n++; end
    stuck = 1'b1;
`ifdef TDC_SEQ_TIMEOUT_EN
    n = 0;
    while (error !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checkOutput("wdog_error", {31'd0, error}, 32'd1);
    checkOutput("wdog_cycles", cyc - last_op_cyc, 32'd255);
    checkOutput("wdog_busy", {31'd0, busy}, 32'd0);
    checkOutput("wdog_cfg_done", {31'd0, cfg_done}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("wdog_sticky", {31'd0, error}, 32'd1);
`else
    repeat (300) @(negedge clk);
    checkOutput("nowdog_error", {31'd0, error}, 32'd0);
    checkOutput("nowdog_busy", {31'd0, busy}, 32'd1);
`endif
    reset = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("final_error", {31'd0, error}, 32'd0);
    checkOutput("final_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("final_ops_left", exp_ops.size(), 32'd0);
    checkOutput("final_hits_left", exp_hits.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
